// File: rtl/order_resolver.sv
// Order-reference resolver: maps decoded ITCH messages onto live-order table
// entries and emits one resolved micro-op per accepted message.
package pipebomb_pkg;
    typedef enum logic [2:0] {
        ITCH_NOP     = 3'd0,
        ITCH_ADD     = 3'd1,
        ITCH_CANCEL  = 3'd2,
        ITCH_EXECUTE = 3'd3,
        ITCH_DELETE  = 3'd4
    } opcode_t;
endpackage

module order_resolver
    import pipebomb_pkg::*;
#(
    parameter int N_ORDERS = 64,
    parameter int REF_W    = 64,
    parameter int PRICE_W  = 48,
    parameter int QTY_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          msg_v,
    output logic                          msg_r,
    input  opcode_t                       msg_opcode,
    input  logic [REF_W-1:0]              msg_ref,
    input  logic                          msg_side,
    input  logic [PRICE_W-1:0]            msg_price,
    input  logic [QTY_W-1:0]              msg_qty,
    output logic                          op_v,
    input  logic                          op_r,
    output logic                          op_valid,
    output opcode_t                       op_opcode,
    output logic                          op_side,
    output logic [PRICE_W-1:0]            op_price,
    output logic [QTY_W-1:0]              op_qty,
    output logic [$clog2(N_ORDERS+1)-1:0] occupancy,
    output logic [CNT_W-1:0]              miss_cnt,
    output logic [CNT_W-1:0]              full_cnt,
    output logic [CNT_W-1:0]              dup_cnt
);

    localparam int IDX_W = (N_ORDERS > 1) ? $clog2(N_ORDERS) : 1;
    localparam int OCC_W = $clog2(N_ORDERS+1);

    logic [N_ORDERS-1:0] tblValid_q;
    logic [REF_W-1:0]    tblRef_q   [N_ORDERS];
    logic                tblSide_q  [N_ORDERS];
    logic [PRICE_W-1:0]  tblPrice_q [N_ORDERS];
    logic [QTY_W-1:0]    tblQty_q   [N_ORDERS];

    logic                opV_q, opValid_q, opSide_q;
    opcode_t             opOpcode_q;
    logic [PRICE_W-1:0]  opPrice_q;
    logic [QTY_W-1:0]    opQty_q;
    logic [OCC_W-1:0]    occ_q;
    logic [CNT_W-1:0]    missCnt_q, fullCnt_q, dupCnt_q;

    logic                opValid_d, opSide_d;
    logic [PRICE_W-1:0]  opPrice_d;
    logic [QTY_W-1:0]    opQty_d;

    logic                accept;
    logic                hit, freeFound;
    logic [IDX_W-1:0]    hitIdx, freeIdx;
    logic [QTY_W-1:0]    hitQty, effQty, remainQty;
    logic                allocEn, qtyWrEn, freeEn;
    logic                missInc, fullInc, dupInc;

    assign msg_r  = !opV_q || op_r;
    assign accept = msg_v && msg_r;

    // Associative lookup and lowest-free-slot search over the current table.
    always_comb begin
        hit       = 1'b0;
        hitIdx    = '0;
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = 0; i < N_ORDERS; i++) begin
            if (!hit && tblValid_q[i] && (tblRef_q[i] == msg_ref)) begin
                hit    = 1'b1;
                hitIdx = IDX_W'(i);
            end
            if (!freeFound && !tblValid_q[i]) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
        end
    end

    assign hitQty    = tblQty_q[hitIdx];
    assign effQty    = (msg_qty < hitQty) ? msg_qty : hitQty;
    assign remainQty = hitQty - effQty;

    always_comb begin
        opValid_d = 1'b0;
        opSide_d  = 1'b0;
        opPrice_d = '0;
        opQty_d   = '0;
        allocEn   = 1'b0;
        qtyWrEn   = 1'b0;
        freeEn    = 1'b0;
        missInc   = 1'b0;
        fullInc   = 1'b0;
        dupInc    = 1'b0;
        case (msg_opcode)
            ITCH_ADD: begin
                if (msg_qty == '0) begin
                    allocEn = 1'b0;
                end else if (hit) begin
                    dupInc = 1'b1;
                end else if (!freeFound) begin
                    fullInc = 1'b1;
                end else begin
                    allocEn   = 1'b1;
                    opValid_d = 1'b1;
                    opSide_d  = msg_side;
                    opPrice_d = msg_price;
                    opQty_d   = msg_qty;
                end
            end
            ITCH_CANCEL, ITCH_EXECUTE: begin
                if (!hit) begin
                    missInc = 1'b1;
                end else begin
                    opValid_d = 1'b1;
                    opSide_d  = tblSide_q[hitIdx];
                    opPrice_d = tblPrice_q[hitIdx];
                    opQty_d   = effQty;
                    qtyWrEn   = 1'b1;
                    freeEn    = (remainQty == '0);
                end
            end
            ITCH_DELETE: begin
                if (!hit) begin
                    missInc = 1'b1;
                end else begin
                    opValid_d = 1'b1;
                    opSide_d  = tblSide_q[hitIdx];
                    opPrice_d = tblPrice_q[hitIdx];
                    opQty_d   = hitQty;
                    freeEn    = 1'b1;
                end
            end
            default: begin
                opValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tblValid_q <= '0;
            occ_q      <= '0;
        end else if (accept) begin
            if (allocEn) begin
                tblValid_q[freeIdx] <= 1'b1;
                occ_q               <= occ_q + 1'b1;
            end else if (freeEn) begin
                tblValid_q[hitIdx]  <= 1'b0;
                occ_q               <= occ_q - 1'b1;
            end
        end
    end

    // Payload storage needs no reset: an entry is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (accept && allocEn) begin
            tblRef_q[freeIdx]   <= msg_ref;
            tblSide_q[freeIdx]  <= msg_side;
            tblPrice_q[freeIdx] <= msg_price;
            tblQty_q[freeIdx]   <= msg_qty;
        end else if (accept && qtyWrEn) begin
            tblQty_q[hitIdx]    <= remainQty;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opV_q      <= 1'b0;
            opValid_q  <= 1'b0;
            opOpcode_q <= ITCH_NOP;
            opSide_q   <= 1'b0;
            opPrice_q  <= '0;
            opQty_q    <= '0;
        end else if (accept) begin
            opV_q      <= 1'b1;
            opValid_q  <= opValid_d;
            opOpcode_q <= msg_opcode;
            opSide_q   <= opSide_d;
            opPrice_q  <= opPrice_d;
            opQty_q    <= opQty_d;
        end else if (op_r) begin
            opV_q      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            missCnt_q <= '0;
            fullCnt_q <= '0;
            dupCnt_q  <= '0;
        end else if (accept) begin
            if (missInc && (missCnt_q != '1)) missCnt_q <= missCnt_q + 1'b1;
            if (fullInc && (fullCnt_q != '1)) fullCnt_q <= fullCnt_q + 1'b1;
            if (dupInc  && (dupCnt_q  != '1)) dupCnt_q  <= dupCnt_q  + 1'b1;
        end
    end

    assign op_v      = opV_q;
    assign op_valid  = opValid_q;
    assign op_opcode = opOpcode_q;
    assign op_side   = opSide_q;
    assign op_price  = opPrice_q;
    assign op_qty    = opQty_q;
    assign occupancy = occ_q;
    assign miss_cnt  = missCnt_q;
    assign full_cnt  = fullCnt_q;
    assign dup_cnt   = dupCnt_q;

endmodule
